// File: rtl/apb2axi_rdf_arb.sv
// Round-robin arbiter for the RDF drain port: grants one requester per tag, issues per-beat
// rdf_data_req pulses, counts beats and reports done/err. Optional watchdog: APB2AXI_RDF_ARB_TIMEOUT_EN.
module apb2axi_rdf_arb #(
    parameter int NUM_REQ     = 2,
    parameter int TAG_W       = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic [NUM_REQ*8-1:0]     req_len,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       beat_valid,
    input  logic [NUM_REQ-1:0]       beat_ready,
    output logic [DATA_W-1:0]        beat_data,
    output logic                     beat_last,
    output logic                     rdf_data_req,
    output logic [TAG_W-1:0]         rdf_data_req_tag,
    input  logic                     rdf_data_valid,
    output logic                     rdf_data_ready,
    input  logic [DATA_W-1:0]        rdf_data_out,
    input  logic                     rdf_data_last,
    output logic                     done_valid,
    output logic [TAG_W-1:0]         done_tag,
    output logic                     done_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   tag_q;
    logic [7:0]         len_q;
    logic [8:0]         beat_cnt;
    logic               err_flag;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     cand;
    logic               in_wait;
    logic               hs;
    logic [8:0]         len_p1;
    logic [8:0]         cnt_inc;
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]        wd_cnt;
`endif

    // Search starts one past the last winner so a persistent requester yields to the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Beat path is combinational; data/last are gated so nothing leaks outside S_WAIT.
    assign in_wait        = (state == S_WAIT);
    assign beat_valid     = in_wait ? (req_grant & {NUM_REQ{rdf_data_valid}}) : '0;
    assign rdf_data_ready = in_wait & rdf_data_valid & |(req_grant & beat_ready);
    assign beat_data      = in_wait ? rdf_data_out : '0;
    assign beat_last      = in_wait & rdf_data_last;
    assign hs             = rdf_data_ready;
    assign len_p1         = {1'b0, len_q} + 9'd1;
    assign cnt_inc        = beat_cnt + 9'd1;

    always_ff @(posedge pclk) begin
        if (state == S_IDLE && win_found) begin
            tag_q <= req_tag[win_idx*TAG_W +: TAG_W];
            len_q <= req_len[win_idx*8 +: 8];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state            <= S_IDLE;
            rr_ptr           <= PTR_W'(NUM_REQ - 1);
            req_grant        <= '0;
            rdf_data_req     <= 1'b0;
            rdf_data_req_tag <= '0;
            done_valid       <= 1'b0;
            done_tag         <= '0;
            done_err         <= 1'b0;
            beat_cnt         <= '0;
            err_flag         <= 1'b0;
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
            wd_cnt           <= '0;
`endif
        end else begin
            rdf_data_req     <= 1'b0;
            rdf_data_req_tag <= '0;
            done_valid       <= 1'b0;
            done_tag         <= '0;
            done_err         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        beat_cnt         <= '0;
                        err_flag         <= 1'b0;
                        req_grant        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        rr_ptr           <= win_idx;
                        rdf_data_req     <= 1'b1;
                        rdf_data_req_tag <= req_tag[win_idx*TAG_W +: TAG_W];
                        state            <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (hs) begin
                        beat_cnt <= cnt_inc;
                        // A beat arriving after the expected count is an overrun; remember it.
                        if (beat_cnt == len_p1 && !rdf_data_last) err_flag <= 1'b1;
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                        if (rdf_data_last) begin
                            done_valid <= 1'b1;
                            done_tag   <= tag_q;
                            done_err   <= err_flag | (cnt_inc != len_p1);
                            state      <= S_DONE;
                        end else begin
                            rdf_data_req     <= 1'b1;
                            rdf_data_req_tag <= tag_q;
                            state            <= S_REQ;
                        end
                    end
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
                    else if (!rdf_data_valid) begin
                        if (wd_cnt == WD_LAST) begin
                            done_valid <= 1'b1;
                            done_tag   <= tag_q;
                            done_err   <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
                    end
`endif
                end
                S_DONE: begin
                    req_grant <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi_rdf_arb.sv
// Randomized bench for apb2axi_rdf_arb against a transaction-level round-robin/beat-count model.
module tb_apb2axi_rdf_arb;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 8;
    localparam int DATA_W  = 32;
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
    localparam int TO_CYC  = 16;
`else
    localparam int TO_CYC  = 1024;
`endif

    logic                     pclk;
    logic                     presetn;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ*8-1:0]     req_len;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ-1:0]       beat_valid;
    logic [NUM_REQ-1:0]       beat_ready;
    logic [DATA_W-1:0]        beat_data;
    logic                     beat_last;
    logic                     rdf_data_req;
    logic [TAG_W-1:0]         rdf_data_req_tag;
    logic                     rdf_data_valid;
    logic                     rdf_data_ready;
    logic [DATA_W-1:0]        rdf_data_out;
    logic                     rdf_data_last;
    logic                     done_valid;
    logic [TAG_W-1:0]         done_tag;
    logic                     done_err;

    int checks = 0;
    int errors = 0;
    int model_rr;
    logic [TAG_W-1:0] tags [NUM_REQ];
    logic [7:0]       lens [NUM_REQ];

    apb2axi_rdf_arb #(
        .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_tag(req_tag), .req_len(req_len), .req_grant(req_grant),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data), .beat_last(beat_last),
        .rdf_data_req(rdf_data_req), .rdf_data_req_tag(rdf_data_req_tag),
        .rdf_data_valid(rdf_data_valid), .rdf_data_ready(rdf_data_ready),
        .rdf_data_out(rdf_data_out), .rdf_data_last(rdf_data_last),
        .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always_comb begin
        req_tag = '0;
        req_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_tag[i*TAG_W +: TAG_W] = tags[i];
            req_len[i*8 +: 8]         = lens[i];
        end
    end

    function automatic int pick(input logic [NUM_REQ-1:0] m);
        for (int k = 1; k <= NUM_REQ; k++)
            if (m[(model_rr + k) % NUM_REQ]) return (model_rr + k) % NUM_REQ;
        return 0;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int w);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic do_txn(input logic [NUM_REQ-1:0] mask, input int beats, input int ready_pct,
                          input int stall_first, input int max_lat, input bit keep, input string name);
        int w, nreq, nhs, cyc, last_hs, lat_cnt, sent, stall_left;
        bit pending, presenting, done;
        logic [NUM_REQ-1:0] exp_gnt;
        logic exp_err, exp_last;
        logic [DATA_W-1:0] exp_data;
        w = pick(mask);
        exp_gnt = onehot(w);
        exp_err = (beats != int'(lens[w]) + 1);
        nreq = 0; nhs = 0; cyc = 0; last_hs = -10; lat_cnt = 0; sent = 0; stall_left = 0;
        pending = 0; presenting = 0; done = 0; exp_data = '0; exp_last = 1'b0;
        @(negedge pclk);
        req_valid = mask;
        while (!done && cyc < 5000) begin
            @(negedge pclk);
            cyc++;
            if (done_valid) begin
                checks++; if (done_tag !== tags[w]) begin errors++; $display("FAIL %s done_tag: got %0h expected %0h", name, done_tag, tags[w]); end
                checks++; if (done_err !== exp_err) begin errors++; $display("FAIL %s done_err: got %0b expected %0b", name, done_err, exp_err); end
                checks++; if (nreq != beats) begin errors++; $display("FAIL %s req_pulses: got %0d expected %0d", name, nreq, beats); end
                checks++; if (nhs != beats) begin errors++; $display("FAIL %s handshakes: got %0d expected %0d", name, nhs, beats); end
                checks++; if (cyc != last_hs + 1) begin errors++; $display("FAIL %s done_latency: got cycle %0d expected %0d", name, cyc, last_hs + 1); end
                checks++; if (req_grant !== exp_gnt) begin errors++; $display("FAIL %s grant_in_done: got %b expected %b", name, req_grant, exp_gnt); end
                done = 1;
            end
            if (rdf_data_req) begin
                nreq++;
                checks++; if (rdf_data_req_tag !== tags[w]) begin errors++; $display("FAIL %s req_tag: got %0h expected %0h", name, rdf_data_req_tag, tags[w]); end
                if (nreq == 1) begin
                    checks++; if (cyc != 1) begin errors++; $display("FAIL %s grant_latency: got %0d expected 1", name, cyc); end
                    checks++; if (req_grant !== exp_gnt) begin errors++; $display("FAIL %s grant: got %b expected %b", name, req_grant, exp_gnt); end
                end
                pending = 1;
                lat_cnt = $urandom_range(max_lat, 0);
            end else if (pending && !presenting) begin
                if (lat_cnt == 0) begin
                    presenting = 1;
                    exp_data   = $urandom;
                    exp_last   = (sent == beats - 1);
                    stall_left = (sent == 0) ? stall_first : 0;
                end else begin
                    lat_cnt--;
                end
            end
            if (presenting) begin
                rdf_data_valid = 1'b1; rdf_data_out = exp_data; rdf_data_last = exp_last;
            end else if (!pending) begin
                rdf_data_valid = 1'($urandom_range(1, 0)); rdf_data_out = $urandom; rdf_data_last = 1'($urandom_range(1, 0));
            end else begin
                rdf_data_valid = 1'b0;
            end
            beat_ready = NUM_REQ'($urandom);
            if (presenting) begin
                if (stall_left > 0) begin beat_ready[w] = 1'b0; stall_left--; end
                else beat_ready[w] = ($urandom_range(99, 0) < ready_pct);
            end
            #1;
            if (presenting) begin
                checks++; if (beat_valid !== exp_gnt) begin errors++; $display("FAIL %s beat_valid: got %b expected %b", name, beat_valid, exp_gnt); end
                checks++; if (rdf_data_ready !== beat_ready[w]) begin errors++; $display("FAIL %s rdf_data_ready: got %0b expected %0b", name, rdf_data_ready, beat_ready[w]); end
                if (beat_ready[w]) begin
                    checks++; if (beat_data !== exp_data) begin errors++; $display("FAIL %s beat_data: got %0h expected %0h", name, beat_data, exp_data); end
                    checks++; if (beat_last !== exp_last) begin errors++; $display("FAIL %s beat_last: got %0b expected %0b", name, beat_last, exp_last); end
                    nhs++; sent++; last_hs = cyc; presenting = 0; pending = 0;
                end
            end else begin
                checks++;
                if (rdf_data_ready !== 1'b0 || beat_valid !== '0) begin
                    errors++; $display("FAIL %s idle_beat_path: got ready=%0b valid=%b expected 0", name, rdf_data_ready, beat_valid);
                end
            end
        end
        if (!done) begin checks++; errors++; $display("FAIL %s done_timeout: got no done expected done", name); end
        rdf_data_valid = 1'b0; rdf_data_last = 1'b0; beat_ready = '0;
        if (!keep) req_valid[w] = 1'b0;
        model_rr = w;
    endtask

    task automatic test_reset;
        presetn = 1'b0; req_valid = '1; beat_ready = '1; rdf_data_valid = 1'b1;
        rdf_data_out = 32'hDEADBEEF; rdf_data_last = 1'b1;
        tags[0] = '0; tags[1] = '0; lens[0] = '0; lens[1] = '0;
        repeat (3) @(negedge pclk);
        checks++;
        if ({req_grant, beat_valid, beat_data, beat_last, rdf_data_req, rdf_data_req_tag,
             rdf_data_ready, done_valid, done_tag, done_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got grant=%b bv=%b data=%0h req=%0b done=%0b expected all 0",
                               req_grant, beat_valid, beat_data, rdf_data_req, done_valid);
        end
        req_valid = '0; rdf_data_valid = 1'b0; rdf_data_last = 1'b0; beat_ready = '0;
        presetn = 1'b1;
        @(negedge pclk);
        checks++; if (req_grant !== '0) begin errors++; $display("FAIL idle_grant: got %b expected 0", req_grant); end
        model_rr = NUM_REQ - 1;
    endtask

    task automatic test_round_robin;
        tags[0] = 8'h11; lens[0] = 8'd0;
        tags[1] = 8'h22; lens[1] = 8'd0;
        do_txn(2'b11, 1, 100, 0, 0, 1, "rr_first");
        do_txn(2'b11, 1, 100, 0, 0, 1, "rr_second");
        do_txn(2'b11, 1, 100, 0, 0, 0, "rr_third");
        req_valid = '0;
    endtask

    task automatic test_basic;
        tags[0] = 8'd3; lens[0] = 8'd3;
        do_txn(2'b01, 4, 100, 0, 0, 0, "basic_len3");
    endtask

    task automatic test_short_err;
        tags[1] = 8'hB7; lens[1] = 8'd3;
        do_txn(2'b10, 2, 100, 0, 1, 0, "short_last");
    endtask

    task automatic test_stall;
        tags[0] = 8'h5C; lens[0] = 8'd1;
        do_txn(2'b01, 2, 100, 5, 0, 0, "stall5");
    endtask

    task automatic test_boundaries;
        tags[1] = 8'h01; lens[1] = 8'd0;
        do_txn(2'b10, 1, 100, 0, 0, 0, "len0");
        tags[0] = 8'hFF; lens[0] = 8'd255;
        do_txn(2'b01, 256, 80, 0, 1, 0, "len255");
        tags[1] = 8'h9E; lens[1] = 8'd1;
        do_txn(2'b10, 4, 90, 0, 1, 0, "extra_beats");
    endtask

    task automatic test_random;
        logic [NUM_REQ-1:0] mask;
        int w, beats;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                tags[i] = TAG_W'($urandom);
                lens[i] = 8'($urandom_range(7, 0));
            end
            mask = NUM_REQ'($urandom_range((1 << NUM_REQ) - 1, 1));
            w = pick(mask);
            beats = ($urandom_range(3, 0) == 0) ? $urandom_range(int'(lens[w]) + 3, 1) : int'(lens[w]) + 1;
            do_txn(mask, beats, $urandom_range(100, 50), $urandom_range(2, 0), 3, 1'($urandom_range(1, 0)), "random");
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midburst;
        int n;
        tags[1] = 8'hC3; lens[1] = 8'd3;
        @(negedge pclk);
        req_valid = 2'b10; rdf_data_valid = 1'b0; beat_ready = '0;
        n = 0;
        do begin @(negedge pclk); n++; end while (!rdf_data_req && n < 10);
        checks++; if (rdf_data_req !== 1'b1) begin errors++; $display("FAIL mid_first_req: got %0b expected 1", rdf_data_req); end
        @(negedge pclk);
        rdf_data_valid = 1'b1; rdf_data_out = $urandom; rdf_data_last = 1'b0; beat_ready = 2'b10;
        #1;
        checks++; if (rdf_data_ready !== 1'b1) begin errors++; $display("FAIL mid_handshake: got %0b expected 1", rdf_data_ready); end
        @(negedge pclk);
        rdf_data_valid = 1'b0; beat_ready = '0;
        checks++; if (rdf_data_req !== 1'b1) begin errors++; $display("FAIL mid_second_req: got %0b expected 1", rdf_data_req); end
        @(negedge pclk);
        rdf_data_valid = 1'b1; req_valid = '0;
        #1 presetn = 1'b0;
        #1;
        checks++;
        if ({req_grant, beat_valid, beat_data, beat_last, rdf_data_req, rdf_data_req_tag,
             rdf_data_ready, done_valid, done_tag, done_err} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got grant=%b bv=%b ready=%0b done=%0b expected all 0",
                               req_grant, beat_valid, rdf_data_ready, done_valid);
        end
        @(negedge pclk);
        rdf_data_valid = 1'b0;
        presetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            checks++;
            if (done_valid !== 1'b0 || req_grant !== '0) begin
                errors++; $display("FAIL mid_no_done: got done=%0b grant=%b expected 0", done_valid, req_grant);
            end
        end
        model_rr = NUM_REQ - 1;
        tags[0] = 8'h44; lens[0] = 8'd0;
        tags[1] = 8'h55; lens[1] = 8'd0;
        do_txn(2'b11, 1, 100, 0, 0, 0, "after_reset");
        req_valid = '0;
    endtask

`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int cyc, cyc_req;
        bit seen_req, seen_done;
        cyc = 0; cyc_req = 0; seen_req = 0; seen_done = 0;
        tags[0] = 8'h5A; lens[0] = 8'd0;
        @(negedge pclk);
        req_valid = 2'b01; rdf_data_valid = 1'b0; beat_ready = '1;
        while (!seen_done && cyc < 100) begin
            @(negedge pclk);
            cyc++;
            if (rdf_data_req && !seen_req) begin seen_req = 1; cyc_req = cyc; end
            if (done_valid) begin
                seen_done = 1;
                checks++; if (cyc != cyc_req + 1 + TO_CYC) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc, cyc_req + 1 + TO_CYC); end
                checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %0b expected 1", done_err); end
                checks++; if (done_tag !== 8'h5A) begin errors++; $display("FAIL timeout_tag: got %0h expected 5a", done_tag); end
            end
        end
        if (!seen_done) begin checks++; errors++; $display("FAIL timeout_done: got no done expected done"); end
        req_valid = '0; beat_ready = '0;
        model_rr = 0;
    endtask
`endif

    initial begin
        test_reset;
        test_round_robin;
        test_basic;
        test_short_err;
        test_stall;
        test_boundaries;
        test_random;
        test_reset_midburst;
`ifdef APB2AXI_RDF_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
